// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready sequencing front-end for the 32-bit ALU.
// Registers a request into the ALU operand regs, gives the ALU one full
// cycle (EXEC), captures result/flags and holds them until consumed (DONE).
// Also tracks consumed-result count and a sticky overflow flag.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_op_i,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  output logic [2:0]       alu_op_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic [31:0]      alu_f_i,
  input  logic             alu_zf_i,
  input  logic             alu_of_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_f_o,
  output logic             out_zf_o,
  output logic             out_of_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic             sticky_of_o,
  input  logic             clr_sticky_i
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct packed {
    logic [31:0] f;
    logic        zf;
    logic        of;
  } rsp_t;

  state_e            state_q, state_d;
  req_t              req_q;
  rsp_t              rsp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sticky_q;

  logic in_hs, out_hs, res_ld;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: DONE can chain straight into EXEC when a new request waits
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs)  state_d = EXEC;
      EXEC:                state_d = DONE;
      DONE:    if (out_hs) state_d = in_valid_i ? EXEC : IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Handshake/strobe decode; in_ready follows out_ready only in DONE
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    res_ld      = 1'b0;
    case (state_q)
      IDLE:    in_ready_o  = 1'b1;
      EXEC:    res_ld      = 1'b1;
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
      end
      default: in_ready_o  = 1'b0;
    endcase
    in_hs  = in_valid_i  & in_ready_o;
    out_hs = out_valid_o & out_ready_i;
  end

  // ALU operand registers: only an accepted request changes them
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    req_q <= '0;
    else if (in_hs) req_q <= '{op: in_op_i, a: in_a_i, b: in_b_i};
  end

  // Result capture after the ALU has had the whole EXEC cycle to settle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     rsp_q <= '0;
    else if (res_ld) rsp_q <= '{f: alu_f_i, zf: alu_zf_i, of: alu_of_i};
  end

  // Consumed-result counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     cnt_q <= '0;
    else if (out_hs) cnt_q <= cnt_q + 1'b1;
  end

  // Sticky overflow: a consumed overflowing result beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 sticky_q <= 1'b0;
    else if (out_hs && rsp_q.of) sticky_q <= 1'b1;
    else if (clr_sticky_i)       sticky_q <= 1'b0;
  end

  assign alu_op_o    = req_q.op;
  assign alu_a_o     = req_q.a;
  assign alu_b_o     = req_q.b;
  assign out_f_o     = rsp_q.f;
  assign out_zf_o    = rsp_q.zf;
  assign out_of_o    = rsp_q.of;
  assign op_count_o  = cnt_q;
  assign sticky_of_o = sticky_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed scenarios plus random
// traffic; a negedge monitor scores results against a queue of expectations.
module tb_alu_issue_ctrl;
  localparam int CNT_W = 4;

  logic             clk, rst_n;
  logic             in_valid, in_ready;
  logic [2:0]       in_op, alu_op;
  logic [31:0]      in_a, in_b, alu_a, alu_b, alu_f, out_f;
  logic             alu_zf, alu_of, out_valid, out_ready, out_zf, out_of;
  logic [CNT_W-1:0] op_count;
  logic             sticky_of, clr_sticky;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_f_i(alu_f), .alu_zf_i(alu_zf), .alu_of_i(alu_of),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_f_o(out_f), .out_zf_o(out_zf), .out_of_o(out_of),
    .op_count_o(op_count), .sticky_of_o(sticky_of),
    .clr_sticky_i(clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB,
  // 110 SLT (signed), 111 SLL; returns {f, zf, of}
  function automatic logic [33:0] alu_model(input logic [2:0] op,
                                            input logic [31:0] a, b);
    logic [31:0] f;
    logic        ov;
    ov = 1'b0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a | b);
      3'd4: begin f = a + b; ov = (a[31] == b[31]) && (f[31] != a[31]); end
      3'd5: begin f = a - b; ov = (a[31] != b[31]) && (f[31] != a[31]); end
      3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = a << b[4:0];
    endcase
    return {f, (f == 32'd0), ov};
  endfunction

  assign {alu_f, alu_zf, alu_of} = alu_model(alu_op, alu_a, alu_b);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [33:0] sb[$];
  logic        exp_ov, exec_flag, prev_hold;
  logic [33:0] held;
  int          m_cnt;
  logic        m_sticky;

  // Expectation producer: each accepted request yields one expected result
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else if (in_valid && in_ready) sb.push_back(alu_model(in_op, in_a, in_b));
  end

  // Monitor: protocol timing, held outputs, results, counter and sticky flag
  always @(negedge clk) begin
    logic [33:0] e;
    logic        o_hs, i_hs;
    if (!rst_n) begin
      exp_ov = 1'b0; exec_flag = 1'b0; prev_hold = 1'b0;
      m_cnt = 0; m_sticky = 1'b0;
    end else begin
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("in_ready", 64'(in_ready), 64'(exp_ov ? out_ready : !exec_flag));
      check("op_count", 64'(op_count), 64'(m_cnt));
      check("sticky_of", 64'(sticky_of), 64'(m_sticky));
      if (prev_hold) check("held_out", 64'({out_f, out_zf, out_of}), 64'(held));
      o_hs = out_valid && out_ready;
      i_hs = in_valid && in_ready;
      if (o_hs) begin
        if (sb.size() == 0) begin
          check("spurious_result", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", 64'({out_f, out_zf, out_of}), 64'(e));
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          if (e[0]) m_sticky = 1'b1;
          else if (clr_sticky) m_sticky = 1'b0;
        end
      end else if (clr_sticky) m_sticky = 1'b0;
      prev_hold = out_valid && !out_ready;
      held      = {out_f, out_zf, out_of};
      exp_ov    = exec_flag ? 1'b1 : (o_hs ? 1'b0 : exp_ov);
      exec_flag = i_hs;
    end
  end

  // ---------------- driver tasks (all at posedge + 1) ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input bit keep);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !out_valid && in_ready;
    end
    if (!ok) check("idle_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_alu", 64'({alu_op, alu_a}), 64'(0));
    check("rst_cnt_sticky", 64'({op_count, sticky_of}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow
    out_ready = 1'b1;
    issue(3'd4, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("add_exec_no_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("add_latency_valid", 64'(out_valid), 64'(1));
    check("add_f", 64'({out_f, out_zf, out_of}), 64'({32'h8000_0000, 1'b0, 1'b1}));
    wait_idle();
    check("add_cnt", 64'(op_count), 64'(1));
    check("add_sticky", 64'(sticky_of), 64'(1));

    // SUB 5-5 with 3-cycle output stall
    out_ready = 1'b0;
    issue(3'd5, 32'd5, 32'd5, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_out", 64'({out_f, out_zf}), 64'({32'd0, 1'b1}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", 64'({out_valid, op_count}), 64'({1'b0, 4'd2}));

    // Back-to-back
    for (int k = 0; k < 4; k++)
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    check("b2b_cnt", 64'(op_count), 64'(6));

    // Reset during EXEC
    issue(3'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_valid", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    check("mid_rst_alu", 64'({alu_op, alu_a, alu_b}), 64'(0));
    check("mid_rst_out", 64'({out_f, out_zf, out_of, op_count, sticky_of}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst", 64'({out_valid, in_ready, op_count}), 64'({1'b0, 1'b1, 4'd0}));

    // Counter wrap over 17 operations
    for (int i = 1; i <= 17; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
      wait_idle();
      if (i == 15) check("cnt_15", 64'(op_count), 64'(15));
      if (i == 16) check("cnt_16", 64'(op_count), 64'(0));
      if (i == 17) check("cnt_17", 64'(op_count), 64'(1));
    end

    // Sticky: set beats same-cycle clear, then lone clear
    out_ready = 1'b0;
    issue(3'd4, 32'h7FFF_FFFF, 32'h1, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1; clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_set_wins", 64'(sticky_of), 64'(1));
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_cleared", 64'(sticky_of), 64'(0));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      in_op      = 3'($urandom_range(0, 7));
      in_a       = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      in_b       = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    wait_idle();
    check("drain_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
